// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package adder_defs;

  localparam int unsigned DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle of the bit-serial adder; master drives operands, slave returns the sum.
import adder_defs::*;

interface serial_adder_if #(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Cout;

  modport master (
    output start, A, B, Cin,
    input  busy, done, S, Cout
  );

  modport slave (
    input  start, A, B, Cin,
    output busy, done, S, Cout
  );

endinterface

// File: rtl/serial_adder_fa.sv
// One-bit full adder assembled from two half adders; the single arithmetic cell of the serial adder.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic s0_s;
  logic c0_s;
  logic c1_s;

  half_adder u_ha0 (.a(a),    .b(b),   .s(s0_s), .c(c0_s));
  half_adder u_ha1 (.a(s0_s), .b(cin), .s(sum),  .c(c1_s));

  assign cout = c0_s | c1_s;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: shifts operands LSB first through one full_adder, one bit per clock.
import adder_defs::*;

module serial_adder #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CW    = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  state_t            state_r;
  state_t            state_next_s;
  logic [WIDTH-1:0]  sha_r;
  logic [WIDTH-1:0]  shb_r;
  logic              carry_r;
  logic [CW-1:0]     cnt_r;
  logic [WIDTH-1:0]  sacc_r;
  logic [WIDTH-1:0]  sacc_next_s;
  logic [WIDTH-1:0]  s_r;
  logic              cout_r;
  logic              busy_r;
  logic              done_r;
  logic              load_s;
  logic              shift_s;
  logic              last_s;
  logic              fa_sum_s;
  logic              fa_cout_s;

  full_adder u_fa (
    .a    (sha_r[0]),
    .b    (shb_r[0]),
    .cin  (carry_r),
    .sum  (fa_sum_s),
    .cout (fa_cout_s)
  );

  assign sacc_next_s = {fa_sum_s, sacc_r[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and datapath control; DONE accepts a new start just like IDLE.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    shift_s      = 1'b0;
    last_s       = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          load_s       = 1'b1;
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        shift_s = 1'b1;
        if (cnt_r == CW'(WIDTH - 1)) begin
          last_s       = 1'b1;
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Operand shifters, carry, bit counter and registered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sha_r   <= '0;
      shb_r   <= '0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
      sacc_r  <= '0;
      s_r     <= '0;
      cout_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      if (load_s) begin
        sha_r   <= bus.A;
        shb_r   <= bus.B;
        carry_r <= bus.Cin;
        cnt_r   <= '0;
        sacc_r  <= '0;
      end else if (shift_s) begin
        sha_r   <= {1'b0, sha_r[WIDTH-1:1]};
        shb_r   <= {1'b0, shb_r[WIDTH-1:1]};
        carry_r <= fa_cout_s;
        cnt_r   <= cnt_r + CW'(1);
        sacc_r  <= sacc_next_s;
      end
      // S and Cout hold between completions, including across a new start.
      if (last_s) begin
        s_r    <= sacc_next_s;
        cout_r <= fa_cout_s;
      end
      done_r <= last_s;
      busy_r <= load_s | (shift_s & ~last_s);
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.S    = s_r;
  assign bus.Cout = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed scenarios plus random operations against A+B+Cin.
module tb_serial_adder;

  localparam int W = 8;
  localparam int LAT = W + 1;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W), .CW(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a request now; the next rising edge accepts it. Returns #1 after that edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.Cin   = cin;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Called #1 after the accepting edge (edge 1). Steps until done is seen or the budget runs out.
  // n is the edge number on which done was seen; operands are scrambled meanwhile.
  task automatic wait_done(input int inject_at, output int n, output int busy_n, output bit overlap);
    n = 1;
    busy_n = (bus.busy === 1'b1) ? 1 : 0;
    overlap = (bus.busy === 1'b1 && bus.done === 1'b1);
    while (bus.done !== 1'b1 && n < 40) begin
      if (inject_at != 0 && n == inject_at) begin
        bus.start = 1'b1;
        bus.A     = 8'hFF;
        bus.B     = 8'hFF;
        bus.Cin   = 1'b1;
      end else begin
        bus.start = 1'b0;
        bus.A     = W'($urandom);
        bus.B     = W'($urandom);
        bus.Cin   = 1'($urandom);
      end
      @(posedge clk);
      #1;
      n++;
      if (bus.busy === 1'b1) busy_n++;
      if (bus.busy === 1'b1 && bus.done === 1'b1) overlap = 1'b1;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.busy, bus.done, bus.S, bus.Cout} !== 11'd0) begin
      bad++;
      $display("FAIL reset_values: got busy=%b done=%b S=%h Cout=%b, expected all zero",
               bus.busy, bus.done, bus.S, bus.Cout);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      total++;
      if ({bus.busy, bus.done, bus.S, bus.Cout} !== 11'd0) begin
        bad++;
        $display("FAIL idle_cycle%0d: got busy=%b done=%b S=%h Cout=%b, expected all zero",
                 i, bus.busy, bus.done, bus.S, bus.Cout);
      end
    end
  endtask

  task automatic test_directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, input int inject_at);
    int n, busy_n, after_done;
    bit overlap;
    logic [W:0] exp;
    exp = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    launch(a, b, cin);
    wait_done(inject_at, n, busy_n, overlap);
    total++;
    if (n !== LAT) begin
      bad++;
      $display("FAIL %s_latency: got done on edge %0d, expected edge %0d", name, n, LAT);
    end
    total++;
    if (busy_n !== W) begin
      bad++;
      $display("FAIL %s_busy_cycles: got %0d, expected %0d", name, busy_n, W);
    end
    total++;
    if (overlap) begin
      bad++;
      $display("FAIL %s_busy_done_overlap: got 1, expected 0", name);
    end
    total++;
    if ({bus.Cout, bus.S} !== exp) begin
      bad++;
      $display("FAIL %s_sum: got Cout=%b S=%h, expected Cout=%b S=%h", name, bus.Cout, bus.S, exp[W], exp[W-1:0]);
    end
    after_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) after_done++;
    end
    total++;
    if (after_done !== 0 || {bus.Cout, bus.S} !== exp) begin
      bad++;
      $display("FAIL %s_after_done: got %0d extra busy/done cycles, Cout=%b S=%h, expected 0 and held %h",
               name, after_done, bus.Cout, bus.S, exp);
    end
  endtask

  task automatic test_back_to_back();
    int n, busy_n;
    bit overlap;
    launch(8'hAA, 8'h55, 1'b0);
    wait_done(0, n, busy_n, overlap);
    total++;
    if (n !== LAT || {bus.Cout, bus.S} !== 9'h0FF) begin
      bad++;
      $display("FAIL b2b_first: got edge %0d Cout=%b S=%h, expected edge %0d Cout=0 S=ff", n, bus.Cout, bus.S, LAT);
    end
    launch(8'h80, 8'h80, 1'b0);
    total++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.S !== 8'hFF) begin
      bad++;
      $display("FAIL b2b_accept_in_done: got busy=%b done=%b S=%h, expected busy=1 done=0 S=ff",
               bus.busy, bus.done, bus.S);
    end
    wait_done(0, n, busy_n, overlap);
    total++;
    if (n !== LAT) begin
      bad++;
      $display("FAIL b2b_gap: got %0d edges between done pulses, expected %0d", n, LAT);
    end
    total++;
    if ({bus.Cout, bus.S} !== 9'h100) begin
      bad++;
      $display("FAIL b2b_second: got Cout=%b S=%h, expected Cout=1 S=00", bus.Cout, bus.S);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int seen_done, seen_busy;
    launch(8'h0F, 8'h0F, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.busy, bus.done, bus.S, bus.Cout} !== 11'd0) begin
      bad++;
      $display("FAIL reset_mid_outputs: got busy=%b done=%b S=%h Cout=%b, expected all zero",
               bus.busy, bus.done, bus.S, bus.Cout);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen_done = 0;
    seen_busy = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) seen_done++;
      if (bus.busy === 1'b1) seen_busy++;
    end
    total++;
    if (seen_done !== 0 || seen_busy !== 0 || bus.S !== 8'h00) begin
      bad++;
      $display("FAIL reset_mid_idle: got done=%0d busy=%0d cycles S=%h, expected 0 0 00", seen_done, seen_busy, bus.S);
    end
    test_directed("post_reset", 8'h03, 8'h04, 1'b0, 0);
  endtask

  task automatic test_random();
    int n, busy_n;
    bit overlap;
    logic [W-1:0] a, b;
    logic cin;
    logic [W:0] exp;
    for (int k = 0; k < 1000; k++) begin
      a   = W'($urandom);
      b   = W'($urandom);
      cin = 1'($urandom);
      if (k % 50 == 0) begin
        a = 8'hFF;
        b = W'(k);
      end
      exp = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      // Half the time chain into the DONE cycle, otherwise spend one idle edge first.
      if ($urandom_range(0, 1) == 0) begin
        @(posedge clk);
        #1;
      end
      launch(a, b, cin);
      wait_done(0, n, busy_n, overlap);
      total++;
      if (n !== LAT || overlap || {bus.Cout, bus.S} !== exp) begin
        bad++;
        $display("FAIL random_op%0d: %h+%h+%b got edge %0d overlap=%b Cout=%b S=%h, expected edge %0d Cout=%b S=%h",
                 k, a, b, cin, n, overlap, bus.Cout, bus.S, LAT, exp[W], exp[W-1:0]);
      end
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Cin   = 1'b0;
    test_reset();
    test_directed("basic", 8'h0F, 8'h01, 1'b0, 0);
    test_directed("ripple", 8'hFF, 8'h01, 1'b1, 0);
    test_directed("ignore_start", 8'h12, 8'h34, 1'b0, 3);
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
